rr_arbiter_83: RTL and testbench
================================

Name: rr_arbiter_83

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a one-hot grant, plus its 3-bit encoded index (same mapping as the 8:3 encoder: bit k -> 3'dk) for the mux/datapath select.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the requester bank and the shared datapath select logic.

Parameters:
- MAX_HOLD, 16, maximum BUSY cycles per grant before a forced release; legal range 1..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; req[k]=1 means requester k wants the resource. Level-sensitive.
- rel  input  1  release strobe from the current owner; sampled only in BUSY.
- gnt  output  8  one-hot grant (registered); all-zero when no owner.
- gnt_id  output  3  encoded index of the owner (registered); valid only when gnt_vld=1.
- gnt_vld  output  1  high while a grant is held (equals |gnt).
- tout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (async assert, sync-style deassert to the rising edge): state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, tout=0, ptr=0, hold_cnt=0.
- State IDLE:
  - If req!=0, pick winner w = the first index with req[w]=1, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - Next edge: gnt=1<<w, gnt_id=w, gnt_vld=1, ptr=(w+1) mod 8 (7 wraps to 0), hold_cnt=0, state=BUSY.
  - If req==0: stay in IDLE, outputs 0.
  - Latency: req seen at edge N -> gnt valid after edge N+1.
- State BUSY:
  - hold_cnt increments each cycle.
  - Release condition at an edge: any of
    - rel=1
    - req[gnt_id]=0 (owner dropped its request)
    - hold_cnt==MAX_HOLD-1
  - On release: gnt=0, gnt_id=0, gnt_vld=0, state=IDLE, hold_cnt=0.
  - tout=1 for exactly one cycle only when the release cause is the hold limit and neither rel nor a req drop was present. If several causes coincide, rel/req-drop win and tout stays 0.
  - Requests from non-owners are ignored while BUSY.
- Handoff: every grant is followed by exactly one idle cycle (gnt=0) before the next grant. Arbitration occurs in that IDLE cycle.
- Fairness: ptr advances past each winner. With all 8 requesting continuously, grants rotate 0,1,...,7,0. Worst-case wait is 7 grants × (MAX_HOLD+1) cycles.
- Hold limit: a grant with no release lasts exactly MAX_HOLD cycles of gnt_vld=1. With MAX_HOLD=1, every grant lasts one cycle and tout pulses every grant.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). ptr returns to 0, so the first grant after reset favours index 0.
- Invariants:
  - gnt is 0 or one-hot.
  - gnt_id == encode(gnt) whenever gnt_vld=1.
  - gnt_vld == |gnt.
  - No X on any output after reset.
- rel asserted in IDLE: ignored.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF -> gnt=0, gnt_id=0, gnt_vld=0, tout=0. Release rst_n, keep req=8'hFF -> first gnt=8'h01, gnt_id=0 after one edge.
- Rotation: req=8'hFF, pulse rel once per grant -> gnt_id sequence 0,1,2,3,4,5,6,7,0. Exactly one gnt=0 cycle between grants.
- Skip/wrap: after a grant to index 6 (ptr=7), req=8'b0000_0101 -> next grant gnt_id=0, then gnt_id=2.
- Timeout: MAX_HOLD=16, req=8'h10 held constant, rel=0 -> gnt=8'h10 for exactly 16 cycles. tout=1 in the cycle gnt drops. Re-grant to index 4 after one idle cycle.
- Owner drop / coincidence: owner 3 drops req[3] at cycle 5 of its grant -> gnt=0 next edge, tout=0. Repeat with rel=1 at hold_cnt=MAX_HOLD-1 -> tout=0.
- Async reset mid-BUSY: assert rst_n=0 off-edge while gnt=8'h20 -> gnt=0 immediately, not waiting for clk. After deassert with req=8'h20 -> gnt=8'h20 again, ptr restarts at 0.

Source files
------------

// File: rtl/rr_arbiter_83.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// Registered one-hot grant plus encoded owner index; one idle cycle between grants.
module rr_arbiter_83 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       tout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [7:0]         gnt_reg, gnt_next;
    logic [2:0]         gnt_id_reg, gnt_id_next;
    logic               tout_reg, tout_next;

    logic [2:0]         win_id;
    logic               win_found;
    logic               owner_drop;
    logic               hit_limit;

    // Scan from the highest offset down so the lowest offset past ptr wins.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_reg + 3'(i)]) begin
                win_id    = ptr_reg + 3'(i);
                win_found = 1'b1;
            end
        end
    end

    assign owner_drop = ~req[gnt_id_reg];
    assign hit_limit  = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        tout_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    gnt_next      = 8'b1 << win_id;
                    gnt_id_next   = win_id;
                    ptr_next      = win_id + 3'd1;
                    hold_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (rel || owner_drop || hit_limit) begin
                    gnt_next      = '0;
                    gnt_id_next   = '0;
                    hold_cnt_next = '0;
                    state_next    = IDLE;
                    // Explicit release or request drop takes precedence over the limit.
                    tout_next     = hit_limit & ~rel & ~owner_drop;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            tout_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            tout_reg     <= tout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign gnt_vld = |gnt_reg;
    assign tout    = tout_reg;

endmodule

// File: tb/tb_rr_arbiter_83.sv
// Bench for rr_arbiter_83: per-cycle vector table fed through an expectation queue,
// plus hand-written asynchronous-reset sequences.
module tb_rr_arbiter_83;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       tout;

    rr_arbiter_83 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tout    (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [7:0] req;
        logic       rel;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       tout;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input string tag, input logic r, input logic [7:0] rq, input logic rl,
                       input logic [7:0] g, input logic [2:0] id, input logic t);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.req = rq; v.rel = rl;
        v.gnt = g; v.id = id; v.vld = |g; v.tout = t;
        vecs.push_back(v);
    endtask

    task automatic expect_now(input string tag, input logic [7:0] g, input logic [2:0] id,
                              input logic t);
        vec_t v;
        v.tag = tag; v.rst_n = rst_n; v.req = req; v.rel = rel;
        v.gnt = g; v.id = id; v.vld = |g; v.tout = t;
        exp_q.push_back(v);
    endtask

    task automatic pop_check();
        vec_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: output seen with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || tout !== e.tout) begin
                n_fail++;
                $display("FAIL %s: got gnt=%h gnt_id=%0d gnt_vld=%b tout=%b, expected gnt=%h gnt_id=%0d gnt_vld=%b tout=%b",
                         e.tag, gnt, gnt_id, gnt_vld, tout, e.gnt, e.id, e.vld, e.tout);
            end else begin
                $display("[txn] %s ok: req=%h rel=%b gnt=%h gnt_id=%0d tout=%b",
                         e.tag, e.req, e.rel, gnt, gnt_id, tout);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        rel   = 1'b0;

        // Reset and first grant
        add("reset_hold", 0, 8'hFF, 0, 8'h00, 0, 0);
        add("first_gnt",  1, 8'hFF, 0, 8'h01, 0, 0);
        // Full rotation with one idle cycle between grants
        for (int k = 1; k <= 8; k++) begin
            add("rot_release", 1, 8'hFF, 1, 8'h00, 0, 0);
            add("rot_gnt",     1, 8'hFF, 0, 8'(1 << (k % 8)), 3'(k % 8), 0);
        end
        // Skip and wrap around ptr=7
        add("skip_rel0",  1, 8'h40, 1, 8'h00, 0, 0);
        add("skip_gnt6",  1, 8'h40, 0, 8'h40, 6, 0);
        add("skip_rel6",  1, 8'h05, 1, 8'h00, 0, 0);
        add("wrap_gnt0",  1, 8'h05, 0, 8'h01, 0, 0);
        add("wrap_rel0",  1, 8'h05, 1, 8'h00, 0, 0);
        add("wrap_gnt2",  1, 8'h05, 0, 8'h04, 2, 0);
        // Hold-limit timeout on requester 4
        add("drop2",      1, 8'h10, 0, 8'h00, 0, 0);
        add("to_gnt4",    1, 8'h10, 0, 8'h10, 4, 0);
        for (int k = 0; k < MAX_HOLD - 1; k++)
            add("to_hold", 1, 8'h10, 0, 8'h10, 4, 0);
        add("to_expire",  1, 8'h10, 0, 8'h00, 0, 1);
        add("to_regrant", 1, 8'h10, 0, 8'h10, 4, 0);
        // Owner drops request mid-grant
        add("drop4",      1, 8'h08, 0, 8'h00, 0, 0);
        add("od_gnt3",    1, 8'h08, 0, 8'h08, 3, 0);
        for (int k = 0; k < 4; k++)
            add("od_hold", 1, 8'h08, 0, 8'h08, 3, 0);
        add("od_drop",    1, 8'h00, 0, 8'h00, 0, 0);
        add("idle_rel",   1, 8'h00, 1, 8'h00, 0, 0);
        // rel coinciding with the hold limit suppresses tout
        add("co_gnt3",    1, 8'h08, 0, 8'h08, 3, 0);
        for (int k = 0; k < MAX_HOLD - 1; k++)
            add("co_hold", 1, 8'h08, 0, 8'h08, 3, 0);
        add("co_rel_lim", 1, 8'h08, 1, 8'h00, 0, 0);
        add("ar_gnt5",    1, 8'h20, 0, 8'h20, 5, 0);
        add("ar_hold5",   1, 8'h20, 0, 8'h20, 5, 0);

        #1;
        expect_now("reset_async_t0", 8'h00, 0, 0);
        pop_check();

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            rel   = vecs[i].rel;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            pop_check();
        end

        // Asynchronous reset off-edge while requester 5 holds the grant
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_clear", 8'h00, 0, 0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h20;
        expect_now("post_rst_gnt5", 8'h20, 5, 0);
        @(posedge clk);
        #1;
        pop_check();

        // Second reset: ptr must restart at 0, so index 0 beats index 5
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_clear2", 8'h00, 0, 0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h21;
        expect_now("ptr_reset_gnt0", 8'h01, 0, 0);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        rel = 1'b1;
        expect_now("ptr_reset_rel", 8'h00, 0, 0);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        rel = 1'b0;
        expect_now("ptr_adv_gnt5", 8'h20, 5, 0);
        @(posedge clk);
        #1;
        pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
